// File: rtl/icache_loader.sv
// Byte-stream loader feeding the instruction cache external write port (IAddrE/IInE/IWriteE).
// Define ICLOAD_CHKSUM_EN to require a trailing XOR checksum byte after the image data.
module icache_loader #(
   parameter int unsigned WORDS = 128,
   parameter int unsigned BASE  = 0
) (
   input  logic        PHI1,
   input  logic        MRST,
   input  logic        LdStart,
   input  logic        LdAbort,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic [31:0] IAddrE,
   output logic [31:0] IInE,
   output logic        IWriteE,
   output logic        CoreHold,
   output logic        LdDone,
   output logic        LdErr,
   output logic [15:0] WordCnt
);

   localparam int unsigned MaxLen = WORDS - BASE;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StHdr   = 3'd1,
      StLoad  = 3'd2,
      StWrite = 3'd3,
`ifdef ICLOAD_CHKSUM_EN
      StChk   = 3'd4,
`endif
      StDone  = 3'd5,
      StErr   = 3'd6
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] len_q, len_d;
   logic [23:0] asm_q, asm_d;
   logic [31:0] iaddr_q, iaddr_d;
   logic [31:0] iin_q, iin_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic        ready_q, ready_d;
   logic        iwrite_q, iwrite_d;
   logic        hold_q, hold_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
`ifdef ICLOAD_CHKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic        xfer;
   logic [15:0] hdr_len;

   // ByteReady is registered, so a transfer is judged against the flopped copy
   assign xfer    = ByteValid & ready_q;
   assign hdr_len = {len_q[15:8], ByteIn};

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      len_d   = len_q;
      asm_d   = asm_q;
      iaddr_d = iaddr_q;
      iin_d   = iin_q;
      wcnt_d  = wcnt_q;
`ifdef ICLOAD_CHKSUM_EN
      csum_d  = csum_q;
`endif

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (LdStart) begin
               state_d = StHdr;
               lane_d  = 2'd0;
               wcnt_d  = 16'd0;
`ifdef ICLOAD_CHKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end

         StHdr: begin
            if (LdAbort) begin
               state_d = StErr;
            end else if (xfer) begin
               if (lane_q == 2'd0) begin
                  len_d[15:8] = ByteIn;
                  lane_d      = 2'd1;
               end else begin
                  len_d  = hdr_len;
                  lane_d = 2'd0;
                  if ((hdr_len == 16'd0) || (32'(hdr_len) > MaxLen)) begin
                     state_d = StErr;
                  end else begin
                     state_d = StLoad;
                  end
               end
            end
         end

         StLoad: begin
            if (LdAbort) begin
               state_d = StErr;
            end else if (xfer) begin
`ifdef ICLOAD_CHKSUM_EN
               csum_d = csum_q ^ ByteIn;
`endif
               if (lane_q == 2'd3) begin
                  iin_d   = {asm_q, ByteIn};
                  iaddr_d = BASE + 32'(wcnt_q);
                  wcnt_d  = wcnt_q + 16'd1;
                  lane_d  = 2'd0;
                  state_d = StWrite;
               end else begin
                  // Shift in so the first byte of the word ends up in bits [31:24]
                  asm_d  = {asm_q[15:0], ByteIn};
                  lane_d = lane_q + 2'd1;
               end
            end
         end

         StWrite: begin
            if (LdAbort) begin
               state_d = StErr;
            end else if (wcnt_q == len_q) begin
`ifdef ICLOAD_CHKSUM_EN
               state_d = StChk;
`else
               state_d = StDone;
`endif
            end else begin
               state_d = StLoad;
            end
         end

`ifdef ICLOAD_CHKSUM_EN
         StChk: begin
            if (LdAbort) begin
               state_d = StErr;
            end else if (xfer) begin
               state_d = (ByteIn == csum_q) ? StDone : StErr;
            end
         end
`endif

         default: state_d = StIdle;
      endcase

      // Flag outputs are decoded from the next state so they are all registered
      ready_d  = (state_d == StHdr) || (state_d == StLoad)
`ifdef ICLOAD_CHKSUM_EN
                 || (state_d == StChk)
`endif
                 ;
      iwrite_d = (state_d == StWrite);
      hold_d   = !((state_d == StIdle) || (state_d == StDone));
      done_d   = (state_d == StDone);
      err_d    = (state_d == StErr);
   end

   always_ff @(posedge PHI1) begin
      if (!MRST) begin
         state_q  <= StIdle;
         lane_q   <= 2'd0;
         len_q    <= 16'd0;
         asm_q    <= 24'd0;
         iaddr_q  <= 32'd0;
         iin_q    <= 32'd0;
         wcnt_q   <= 16'd0;
         ready_q  <= 1'b0;
         iwrite_q <= 1'b0;
         hold_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef ICLOAD_CHKSUM_EN
         csum_q   <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         len_q    <= len_d;
         asm_q    <= asm_d;
         iaddr_q  <= iaddr_d;
         iin_q    <= iin_d;
         wcnt_q   <= wcnt_d;
         ready_q  <= ready_d;
         iwrite_q <= iwrite_d;
         hold_q   <= hold_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef ICLOAD_CHKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   assign ByteReady = ready_q;
   assign IAddrE    = iaddr_q;
   assign IInE      = iin_q;
   assign IWriteE   = iwrite_q;
   assign CoreHold  = hold_q;
   assign LdDone    = done_q;
   assign LdErr     = err_q;
   assign WordCnt   = wcnt_q;

endmodule
